ps2_scancode_ctrl: RTL and testbench

- Sequences the PS/2 keyboard receiver FIFO: pops raw bytes through its ready/nextdata_n handshake and folds Set-2 prefix sequences (E0, F0, E1 Pause) into single key events.
- Presents key events to the CPU-side peripheral logic over a valid/ready interface.
- Back-pressure from the consumer leaves bytes queued in the receiver FIFO.

---
 rtl/ps2_scancode_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ps2_scancode_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 Set-2 scan-code sequencer: pops the receiver FIFO and folds E0/F0/E1 prefixes into key events.
// Optional held-key make filter enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_scancode_ctrl #(
  parameter int unsigned     TO_W      = 20,
  parameter logic [TO_W-1:0] TO_CYCLES = 20'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_ready,
  input  logic [7:0] kb_data,
  output logic       kb_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_rel,
  output logic       bat_ok,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, POP, SKIP_POP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_CYCLES - TO_W'(1);

  state_t          state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            ext_f_q, ext_f_d;
  logic            rel_f_q, rel_f_d;
  logic [2:0]      skip_q, skip_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            evt_valid_q, evt_valid_d;
  logic [7:0]      evt_code_q, evt_code_d;
  logic            evt_ext_q, evt_ext_d;
  logic            evt_rel_q, evt_rel_d;
  logic            bat_ok_q, bat_ok_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            fetch;
  logic            pending;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0]    held_q, held_d;
  logic [8:0]      held_idx;
`endif

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    ext_f_d       = ext_f_q;
    rel_f_d       = rel_f_q;
    skip_d        = skip_q;
    to_cnt_d      = '0;
    evt_valid_d   = evt_valid_q;
    evt_code_d    = evt_code_q;
    evt_ext_d     = evt_ext_q;
    evt_rel_d     = evt_rel_q;
    bat_ok_d      = 1'b0;
    err_cnt_d     = err_cnt_q;
    kb_nextdata_n = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
    held_d        = held_q;
    held_idx      = {ext_f_q, byte_q};
`endif

    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;

    // Only fetch when the event slot is free (or draining this cycle) so no event is overwritten.
    fetch   = kb_ready && (!evt_valid_q || evt_ready);
    pending = ext_f_q || rel_f_q || (skip_q != 3'd0);

    case (state_q)
      IDLE: begin
        if (fetch) begin
          byte_d  = kb_data;
          state_d = (skip_q != 3'd0) ? SKIP_POP : POP;
        end else if ((TO_CYCLES != '0) && pending && !kb_ready) begin
          if (to_cnt_q == TO_LAST) begin
            ext_f_d = 1'b0;
            rel_f_d = 1'b0;
            skip_d  = 3'd0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end

      POP: begin
        kb_nextdata_n = 1'b0;
        state_d       = IDLE;
        case (byte_q)
          8'hE0: ext_f_d = 1'b1;
          8'hF0: rel_f_d = 1'b1;
          8'hE1: skip_d  = 3'd7;
          8'h00, 8'hFF: begin
            ext_f_d = 1'b0;
            rel_f_d = 1'b0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
          default: begin
            ext_f_d = 1'b0;
            rel_f_d = 1'b0;
            if (byte_q == 8'hAA && !ext_f_q && !rel_f_q) begin
              bat_ok_d = 1'b1;
            end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
              held_d[held_idx] = !rel_f_q;
              if (rel_f_q || !held_q[held_idx]) begin
                evt_valid_d = 1'b1;
                evt_code_d  = byte_q;
                evt_ext_d   = ext_f_q;
                evt_rel_d   = rel_f_q;
              end
`else
              evt_valid_d = 1'b1;
              evt_code_d  = byte_q;
              evt_ext_d   = ext_f_q;
              evt_rel_d   = rel_f_q;
`endif
            end
          end
        endcase
      end

      SKIP_POP: begin
        kb_nextdata_n = 1'b0;
        state_d       = IDLE;
        skip_d        = skip_q - 3'd1;
        if (skip_q == 3'd1) begin
          evt_valid_d = 1'b1;
          evt_code_d  = 8'hE1;
          evt_ext_d   = 1'b0;
          evt_rel_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      ext_f_q     <= 1'b0;
      rel_f_q     <= 1'b0;
      skip_q      <= '0;
      to_cnt_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_ext_q   <= 1'b0;
      evt_rel_q   <= 1'b0;
      bat_ok_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      ext_f_q     <= ext_f_d;
      rel_f_q     <= rel_f_d;
      skip_q      <= skip_d;
      to_cnt_q    <= to_cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ext_q   <= evt_ext_d;
      evt_rel_q   <= evt_rel_d;
      bat_ok_q    <= bat_ok_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst) held_q <= '0;
    else     held_q <= held_d;
  end
`endif

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_ext   = evt_ext_q;
  assign evt_rel   = evt_rel_q;
  assign bat_ok    = bat_ok_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Bench for ps2_scancode_ctrl: sequence-level decode model plus per-cycle handshake/pop checks.
module tb_ps2_scancode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       kb_ready;
  logic [7:0] kb_data;
  logic       kb_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_rel;
  logic       bat_ok;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  ps2_scancode_ctrl #(.TO_W(20), .TO_CYCLES(20'd16)) dut (
    .clk(clk), .rst(rst), .kb_ready(kb_ready), .kb_data(kb_data),
    .kb_nextdata_n(kb_nextdata_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_rel(evt_rel),
    .bat_ok(bat_ok), .err_cnt(err_cnt)
  );

  // Receiver FIFO: bytes between feed_rd and feed_wr are queued; head advances after a pop edge.
  logic [7:0] feed [0:2047];
  int feed_wr = 0;
  int feed_rd = 0;
  assign kb_ready = (feed_rd != feed_wr);
  assign kb_data  = feed[feed_rd];

  int total = 0;
  int bad   = 0;

  // Model state: decoded purely from the byte stream, in order.
  int           m_ext, m_rel, m_skip, m_err, m_bat;
  logic [511:0] m_held;
  logic [9:0]   exp_mem [0:1023];
  int           exp_wr = 0;
  int           exp_rd = 0;

  // Observation state
  logic       nd, nd_prev, prev_stall, bat_prev;
  logic [9:0] held_ev, last_ev;
  int         pops, evs, bats;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic void emit(input logic [7:0] c, input logic e, input logic r, input logic filt);
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (filt) begin
      if (!r && m_held[{e, c}]) return;
      m_held[{e, c}] = !r;
    end
`endif
    exp_mem[exp_wr] = {e, r, c};
    exp_wr++;
  endfunction

  function automatic void decode(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) emit(8'hE1, 1'b0, 1'b0, 1'b0);
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'h00 || b == 8'hFF) begin
      if (m_err < 255) m_err++;
      m_ext = 0; m_rel = 0;
    end else if (b == 8'hAA && m_ext == 0 && m_rel == 0) m_bat++;
    else begin
      emit(b, m_ext[0], m_rel[0], 1'b1);
      m_ext = 0; m_rel = 0;
    end
  endfunction

  function automatic void model_timeout();
    m_ext = 0; m_rel = 0; m_skip = 0;
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_reset();
    m_ext = 0; m_rel = 0; m_skip = 0; m_err = 0; m_bat = 0; m_held = '0;
    exp_rd = exp_wr;
  endfunction

  function automatic void push(input logic [7:0] b);
    feed[feed_wr] = b;
    feed_wr++;
    decode(b);
  endfunction

  // One clock: check at the negedge against inputs as the next posedge will see them.
  task automatic step();
    if (!rst) begin
      if (prev_stall) chk("evt_hold", {evt_valid, evt_ext, evt_rel, evt_code}, {1'b1, held_ev});
      if (evt_valid && evt_ready) begin
        evs++;
        last_ev = {evt_ext, evt_rel, evt_code};
        if (exp_rd < exp_wr) begin
          chk("evt", {evt_ext, evt_rel, evt_code}, exp_mem[exp_rd]);
          exp_rd++;
        end else begin
          total++; bad++;
          $display("FAIL evt_unexpected: got %0h expected no event", {evt_ext, evt_rel, evt_code});
        end
      end
      prev_stall = evt_valid && !evt_ready;
      held_ev    = {evt_ext, evt_rel, evt_code};
      if (kb_nextdata_n == 1'b0) begin
        pops++;
        chk("pop_gap", nd_prev, 1);
        chk("pop_nonempty", kb_ready, 1);
      end
      if (bat_ok) begin
        bats++;
        chk("bat_width", bat_prev, 0);
      end
      bat_prev = bat_ok;
    end
    nd      = kb_nextdata_n;
    nd_prev = kb_nextdata_n;
    @(posedge clk);
    #1;
    if (nd == 1'b0 && feed_rd < feed_wr) feed_rd++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    prev_stall = 1'b0;
    bat_prev   = 1'b0;
    nd_prev    = 1'b1;
    run(3);
    chk("rst_vals", {kb_nextdata_n, evt_valid, evt_code, evt_ext, evt_rel, bat_ok, err_cnt},
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;
    pops = 0; evs = 0; bats = 0;
  endtask

  task automatic end_test(input string name);
    chk({name, "_drain"}, exp_rd, exp_wr);
    chk({name, "_rx_empty"}, feed_rd, feed_wr);
    chk({name, "_bat_cnt"}, bats, m_bat);
    chk({name, "_err_cnt"}, err_cnt, m_err);
  endtask

  initial begin
    rst = 1'b1; evt_ready = 1'b1;
    prev_stall = 1'b0; bat_prev = 1'b0; nd_prev = 1'b1;
    pops = 0; evs = 0; bats = 0; last_ev = '0; held_ev = '0;
    model_reset();
    @(negedge clk);

    // Reset values, and a byte queued during reset is fetched afterwards
    do_reset();
    rst = 1'b1;
    push(8'h2B);
    run(3);
    chk("rst_no_pop", kb_ready, 1);
    rst = 1'b0;
    run(6);
    chk("survive_ev", last_ev, 10'h02B);
    end_test("t0");

    // Make then release: three single-cycle pops
    do_reset();
    push(8'h1C); push(8'hF0); push(8'h1C);
    run(12);
    chk("t1_pops", pops, 3);
    chk("t1_evs", evs, 2);
    chk("t1_last", last_ev, 10'h11C);
    end_test("t1");

    // Extended release, then flags must be clear for the next key
    do_reset();
    push(8'hE0); push(8'hF0); push(8'h75);
    run(10);
    chk("t2_ev", last_ev, 10'h375);
    push(8'h1C);
    run(6);
    chk("t2_flags_clear", last_ev, 10'h01C);
    end_test("t2");

    // Back-pressure holds the event and leaves the next byte queued
    do_reset();
    evt_ready = 1'b0;
    push(8'h1C);
    run(3);
    push(8'h32);
    pops = 0;
    run(6);
    chk("bp_nopop", pops, 0);
    chk("bp_code", evt_code, 8'h1C);
    evt_ready = 1'b1;
    step();
    chk("bp_gap_valid", evt_valid, 0);
    step();
    chk("bp_next", {evt_valid, evt_code}, {1'b1, 8'h32});
    run(4);
    end_test("t3");

    // Pause sequence folds to one event
    do_reset();
    push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
    push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
    run(24);
    chk("t4_pops", pops, 8);
    chk("t4_evs", evs, 1);
    chk("t4_ev", last_ev, 10'h0E1);
    end_test("t4");

    // Timeout boundary: fetch on the 16th idle cycle wins; one more idle cycle expires
    do_reset();
    push(8'hE0);
    run(17);
    push(8'h1C);
    run(6);
    chk("to_edge_ev", last_ev, 10'h21C);
    chk("to_edge_err", err_cnt, 0);
    push(8'hE0);
    run(18);
    model_timeout();
    push(8'h1C);
    run(6);
    chk("to_exp_ev", last_ev, 10'h01C);
    chk("to_exp_err", err_cnt, 1);
    end_test("t5");

    // BAT: unprefixed AA pulses bat_ok with no event; prefixed AA is a key event
    do_reset();
    push(8'hAA);
    run(6);
    chk("bat_pulse", bats, 1);
    chk("bat_no_evt", evs, 0);
    push(8'hF0); push(8'hAA);
    run(8);
    chk("aa_rel_ev", last_ev, 10'h1AA);
    end_test("t6");

    // Overrun bytes count and clear pending prefixes
    do_reset();
    push(8'h00); push(8'hFF);
    run(8);
    chk("ovr_err", err_cnt, 2);
    push(8'hE0); push(8'h00); push(8'h1C);
    run(10);
    chk("ovr_flags_clear", last_ev, 10'h01C);
    chk("ovr_err2", err_cnt, 3);
    end_test("t7");

    // Typematic repeats
    do_reset();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C); push(8'h1C);
    run(20);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("tm_evs", evs, 3);
`else
    chk("tm_evs", evs, 5);
`endif
    end_test("t8");

    // Mixed traffic under intermittent back-pressure
    do_reset();
    begin
      logic [7:0] mix [0:17];
      mix = '{8'h16, 8'hE0, 8'h6B, 8'hF0, 8'h16, 8'hE0, 8'hF0, 8'h6B, 8'h29,
              8'hAA, 8'hF0, 8'h29, 8'h5A, 8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14};
      for (int i = 0; i < 18; i++) push(mix[i]);
      for (int i = 0; i < 60; i++) begin
        evt_ready = (i % 3 != 1);
        step();
      end
      evt_ready = 1'b1;
      run(10);
    end
    chk("mix_evs", evs, 9);
    end_test("t9");

    // err_cnt saturates
    do_reset();
    for (int i = 0; i < 300; i++) push(8'hFF);
    run(620);
    chk("err_sat", err_cnt, 255);
    end_test("t10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
